// File: rtl/id_pkg.sv
// Shared constants and helpers for the MIPS instruction-decode stage.
package id_pkg;

    localparam int REG_ADDR_W = 5;

    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // A bubble carries an all-zero control word, so it never writes or accesses memory.
    localparam logic BUBBLE_CTRL_BIT = 1'b0;

    // Result is 64 bits wide; callers keep the low DATA_W bits.
    function automatic logic [63:0] extend_imm(input logic [15:0] imm, input logic zext);
        if (zext) begin
            return {48'd0, imm};
        end
        return {{48{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_register_file.sv
// Architectural register file: two combinational read ports, one write port, $0 fixed at zero.
module id_register_file
    import id_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]     rdata_a,
    output logic [DATA_W-1:0]     rdata_b
);

    localparam int IDX_W = $clog2(REG_CNT);
    localparam logic [REG_ADDR_W:0] REG_CNT_L = (REG_ADDR_W+1)'(REG_CNT);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    always_comb begin
        for (int i = 0; i < REG_CNT; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != '0) && ({1'b0, waddr} < REG_CNT_L)) begin
            regs_d[waddr[IDX_W-1:0]] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_CNT; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Out-of-range indices read as zero rather than aliasing onto a real register.
    assign rdata_a = ({1'b0, raddr_a} < REG_CNT_L) ? regs_q[raddr_a[IDX_W-1:0]] : '0;
    assign rdata_b = ({1'b0, raddr_b} < REG_CNT_L) ? regs_q[raddr_b[IDX_W-1:0]] : '0;

endmodule

// File: rtl/id_stage_pipelined.sv
// Registered MIPS ID stage: register file, MEM/WB forwarding, load-use stall, ID/EX register.
// Define ID_PERF_CNT_EN to add the saturating Stall_Count output.
module id_stage_pipelined
    import id_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_CNT     = 32,
    parameter int CTRL_W      = 16,
    parameter int MEMREAD_BIT = 3,
    parameter int ZEXT_BIT    = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [31:0]           Instr_In,
    input  logic [31:0]           PC4_In,
    input  logic                  Valid_In,
    input  logic [CTRL_W-1:0]     Ctrl_In,
    input  logic                  Uses_Rs,
    input  logic                  Uses_Rt,
    input  logic                  Flush_In,
    input  logic                  MEM_RegWrite,
    input  logic [REG_ADDR_W-1:0] MEM_WriteReg,
    input  logic [DATA_W-1:0]     MEM_Data,
    input  logic                  WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_WriteReg,
    input  logic [DATA_W-1:0]     WB_Data,
    output logic                  Stall_Out,
    output logic                  EX_Valid,
    output logic [CTRL_W-1:0]     EX_Ctrl,
    output logic [DATA_W-1:0]     EX_RsData,
    output logic [DATA_W-1:0]     EX_RtData,
    output logic [DATA_W-1:0]     EX_Imm,
    output logic [REG_ADDR_W-1:0] EX_Rs,
    output logic [REG_ADDR_W-1:0] EX_Rt,
    output logic [REG_ADDR_W-1:0] EX_Rd,
    output logic [31:0]           EX_PC4
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]           Stall_Count
`endif
);

    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [15:0]           imm;
    logic [5:0]            unused_opcode;
    logic [DATA_W-1:0]     rs_rf, rt_rf, rs_val, rt_val, imm_ext;
    logic [63:0]           imm_wide;
    logic                  hazard, load_bubble;

    logic                  ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0]     ex_ctrl_q, ex_ctrl_d;
    logic [DATA_W-1:0]     ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0]     ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0]     ex_imm_q, ex_imm_d;
    logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
    logic [31:0]           ex_pc4_q, ex_pc4_d;

    assign rs            = Instr_In[RS_HI:RS_LO];
    assign rt            = Instr_In[RT_HI:RT_LO];
    assign rd            = Instr_In[RD_HI:RD_LO];
    assign imm           = Instr_In[IMM_HI:IMM_LO];
    assign unused_opcode = Instr_In[31:26];

    id_register_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_regfile (
        .clk     (Clk),
        .reset   (Reset),
        .we      (WB_RegWrite),
        .waddr   (WB_WriteReg),
        .wdata   (WB_Data),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_rf),
        .rdata_b (rt_rf)
    );

    // MEM is the younger producer, so it wins over WB for the same register.
    function automatic logic [DATA_W-1:0] select_operand(
        input logic [REG_ADDR_W-1:0] field,
        input logic [DATA_W-1:0]     rf_value
    );
        if (field == '0) return '0;
        if (MEM_RegWrite && (MEM_WriteReg == field)) return MEM_Data;
        if (WB_RegWrite && (WB_WriteReg == field)) return WB_Data;
        return rf_value;
    endfunction

    always_comb begin
        rs_val   = select_operand(rs, rs_rf);
        rt_val   = select_operand(rt, rt_rf);
        imm_wide = extend_imm(imm, Ctrl_In[ZEXT_BIT]);
        imm_ext  = imm_wide[DATA_W-1:0];
    end

    always_comb begin
        hazard = Valid_In && ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rt_q != '0) &&
                 ((Uses_Rs && (rs == ex_rt_q)) || (Uses_Rt && (rt == ex_rt_q)));
        load_bubble = Flush_In || !Valid_In || hazard;
    end

    assign Stall_Out = hazard && !Flush_In;

    always_comb begin
        ex_valid_d   = 1'b0;
        ex_ctrl_d    = {CTRL_W{BUBBLE_CTRL_BIT}};
        ex_rs_data_d = '0;
        ex_rt_data_d = '0;
        ex_imm_d     = '0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_rd_d      = '0;
        ex_pc4_d     = '0;
        if (!load_bubble) begin
            ex_valid_d   = 1'b1;
            ex_ctrl_d    = Ctrl_In;
            ex_rs_data_d = rs_val;
            ex_rt_data_d = rt_val;
            ex_imm_d     = imm_ext;
            ex_rs_d      = rs;
            ex_rt_d      = rt;
            ex_rd_d      = rd;
            ex_pc4_d     = PC4_In;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_pc4_q     <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_pc4_q     <= ex_pc4_d;
        end
    end

    assign EX_Valid  = ex_valid_q;
    assign EX_Ctrl   = ex_ctrl_q;
    assign EX_RsData = ex_rs_data_q;
    assign EX_RtData = ex_rt_data_q;
    assign EX_Imm    = ex_imm_q;
    assign EX_Rs     = ex_rs_q;
    assign EX_Rt     = ex_rt_q;
    assign EX_Rd     = ex_rd_q;
    assign EX_PC4    = ex_pc4_q;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (Stall_Out && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign Stall_Count = stall_count_q;
`endif

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed self-checking bench for id_stage_pipelined (default parameters).
module tb_id_stage_pipelined;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr_In, PC4_In;
    logic        Valid_In;
    logic [15:0] Ctrl_In;
    logic        Uses_Rs, Uses_Rt, Flush_In;
    logic        MEM_RegWrite, WB_RegWrite;
    logic [4:0]  MEM_WriteReg, WB_WriteReg;
    logic [31:0] MEM_Data, WB_Data;
    logic        Stall_Out, EX_Valid;
    logic [15:0] EX_Ctrl;
    logic [31:0] EX_RsData, EX_RtData, EX_Imm, EX_PC4;
    logic [4:0]  EX_Rs, EX_Rt, EX_Rd;
`ifdef ID_PERF_CNT_EN
    logic [31:0] Stall_Count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    id_stage_pipelined dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Instr_In     (Instr_In),
        .PC4_In       (PC4_In),
        .Valid_In     (Valid_In),
        .Ctrl_In      (Ctrl_In),
        .Uses_Rs      (Uses_Rs),
        .Uses_Rt      (Uses_Rt),
        .Flush_In     (Flush_In),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_WriteReg (MEM_WriteReg),
        .MEM_Data     (MEM_Data),
        .WB_RegWrite  (WB_RegWrite),
        .WB_WriteReg  (WB_WriteReg),
        .WB_Data      (WB_Data),
        .Stall_Out    (Stall_Out),
        .EX_Valid     (EX_Valid),
        .EX_Ctrl      (EX_Ctrl),
        .EX_RsData    (EX_RsData),
        .EX_RtData    (EX_RtData),
        .EX_Imm       (EX_Imm),
        .EX_Rs        (EX_Rs),
        .EX_Rt        (EX_Rt),
        .EX_Rd        (EX_Rd),
        .EX_PC4       (EX_PC4)
`ifdef ID_PERF_CNT_EN
        ,
        .Stall_Count  (Stall_Count)
`endif
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one IF/ID instruction just after the falling edge; forwarding inputs are left idle.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc4, input logic valid,
                                 input logic [15:0] ctrl, input logic urs, input logic urt,
                                 input logic flush);
        @(negedge Clk);
        Instr_In     = instr;
        PC4_In       = pc4;
        Valid_In     = valid;
        Ctrl_In      = ctrl;
        Uses_Rs      = urs;
        Uses_Rt      = urt;
        Flush_In     = flush;
        MEM_RegWrite = 1'b0;
        MEM_WriteReg = 5'd0;
        MEM_Data     = 32'd0;
        WB_RegWrite  = 1'b0;
        WB_WriteReg  = 5'd0;
        WB_Data      = 32'd0;
    endtask

    task automatic clockEdge();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        applyStimulus(rtype(5'd1, 5'd2, 5'd3), 32'h104, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        clockEdge();
        clockEdge();
        checkOutput("reset_ex_valid", EX_Valid, 0);
        checkOutput("reset_ex_ctrl", EX_Ctrl, 0);
        checkOutput("reset_ex_pc4", EX_PC4, 0);
        checkOutput("reset_ex_rd", EX_Rd, 0);
        checkOutput("reset_stall", Stall_Out, 0);

        // add $3,$1,$2 out of reset: registers all zero
        applyStimulus(rtype(5'd1, 5'd2, 5'd3), 32'h104, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        Reset = 1'b0;
        clockEdge();
        checkOutput("add_valid", EX_Valid, 1);
        checkOutput("add_rsdata", EX_RsData, 0);
        checkOutput("add_rtdata", EX_RtData, 0);
        checkOutput("add_rd", EX_Rd, 3);
        checkOutput("add_rs", EX_Rs, 1);
        checkOutput("add_rt", EX_Rt, 2);
        checkOutput("add_ctrl", EX_Ctrl, 32'h0101);
        checkOutput("add_pc4", EX_PC4, 32'h104);
        checkOutput("add_imm", EX_Imm, 32'h0000_1820);

        // WB write of $1 in the same cycle it is read
        applyStimulus(rtype(5'd1, 5'd2, 5'd3), 32'h108, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd1; WB_Data = 32'h0000_1234;
        clockEdge();
        checkOutput("wb_bypass_rs", EX_RsData, 32'h0000_1234);

        applyStimulus(rtype(5'd1, 5'd2, 5'd3), 32'h10C, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        clockEdge();
        checkOutput("rf_read_rs", EX_RsData, 32'h0000_1234);

        applyStimulus(rtype(5'd1, 5'd2, 5'd3), 32'h110, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd2; WB_Data = 32'h0000_0055;
        clockEdge();
        checkOutput("wb_bypass_rt", EX_RtData, 32'h0000_0055);

        // $0 write attempt must not stick
        applyStimulus(rtype(5'd0, 5'd2, 5'd3), 32'h114, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        WB_RegWrite = 1'b1; WB_WriteReg = 5'd0; WB_Data = 32'hFFFF_FFFF;
        clockEdge();
        checkOutput("r0_during_write", EX_RsData, 0);
        checkOutput("rf_read_rt", EX_RtData, 32'h0000_0055);

        applyStimulus(rtype(5'd0, 5'd0, 5'd3), 32'h118, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        clockEdge();
        checkOutput("r0_rs_after", EX_RsData, 0);
        checkOutput("r0_rt_after", EX_RtData, 0);

        // MEM and WB both target $4: MEM wins
        applyStimulus(rtype(5'd4, 5'd2, 5'd7), 32'h11C, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd4; MEM_Data = 32'h0000_AAAA;
        WB_RegWrite  = 1'b1; WB_WriteReg  = 5'd4; WB_Data  = 32'h0000_BBBB;
        clockEdge();
        checkOutput("mem_over_wb", EX_RsData, 32'h0000_AAAA);
        checkOutput("mem_wb_rt_rf", EX_RtData, 32'h0000_0055);

        applyStimulus(rtype(5'd4, 5'd2, 5'd7), 32'h120, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd2; MEM_Data = 32'h0000_CCCC;
        clockEdge();
        checkOutput("wb_value_stored", EX_RsData, 32'h0000_BBBB);
        checkOutput("mem_fwd_rt", EX_RtData, 32'h0000_CCCC);

        // Immediate extension
        applyStimulus(itype(6'h08, 5'd0, 5'd9, 16'h8000), 32'h124, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        clockEdge();
        checkOutput("imm_sext", EX_Imm, 32'hFFFF_8000);

        applyStimulus(itype(6'h0D, 5'd0, 5'd9, 16'h8000), 32'h128, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0);
        clockEdge();
        checkOutput("imm_zext", EX_Imm, 32'h0000_8000);

        applyStimulus(itype(6'h08, 5'd0, 5'd9, 16'h7FFF), 32'h12C, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        clockEdge();
        checkOutput("imm_sext_pos", EX_Imm, 32'h0000_7FFF);

        // Invalid slot becomes a bubble
        applyStimulus(rtype(5'd1, 5'd2, 5'd3), 32'h130, 1'b0, 16'h0101, 1'b1, 1'b1, 1'b0);
        clockEdge();
        checkOutput("invalid_valid", EX_Valid, 0);
        checkOutput("invalid_ctrl", EX_Ctrl, 0);
        checkOutput("invalid_rd", EX_Rd, 0);

        // lw $5 then add $6,$5,$2: one stall cycle, then forwarded load data
        applyStimulus(itype(6'h23, 5'd0, 5'd5, 16'h0000), 32'h134, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("lw_no_stall", Stall_Out, 0);
        clockEdge();
        checkOutput("lw_valid", EX_Valid, 1);
        checkOutput("lw_rt", EX_Rt, 5);

        applyStimulus(rtype(5'd5, 5'd2, 5'd6), 32'h138, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        #1 checkOutput("hazard_stall", Stall_Out, 1);
        clockEdge();
        checkOutput("hazard_bubble", EX_Valid, 0);
        checkOutput("hazard_bubble_ctrl", EX_Ctrl, 0);

        applyStimulus(rtype(5'd5, 5'd2, 5'd6), 32'h138, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        MEM_RegWrite = 1'b1; MEM_WriteReg = 5'd5; MEM_Data = 32'h0000_DEAD;
        #1 checkOutput("stall_one_cycle", Stall_Out, 0);
        clockEdge();
        checkOutput("held_add_valid", EX_Valid, 1);
        checkOutput("held_add_rsdata", EX_RsData, 32'h0000_DEAD);
        checkOutput("held_add_rd", EX_Rd, 6);
`ifdef ID_PERF_CNT_EN
        checkOutput("stall_count_one", Stall_Count, 1);
`endif

        // Flush during the hazard cycle
        applyStimulus(itype(6'h23, 5'd0, 5'd5, 16'h0000), 32'h13C, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
        clockEdge();
        applyStimulus(rtype(5'd2, 5'd5, 5'd6), 32'h140, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b1);
        #1 checkOutput("flush_no_stall", Stall_Out, 0);
        clockEdge();
        checkOutput("flush_bubble", EX_Valid, 0);
        checkOutput("flush_bubble_ctrl", EX_Ctrl, 0);

        // Hazard through the rt operand
        applyStimulus(itype(6'h23, 5'd0, 5'd5, 16'h0000), 32'h144, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
        clockEdge();
        applyStimulus(rtype(5'd2, 5'd5, 5'd6), 32'h148, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        #1 checkOutput("rt_hazard_stall", Stall_Out, 1);
        clockEdge();
        checkOutput("rt_hazard_bubble", EX_Valid, 0);

        // Load into $0 never causes a stall
        applyStimulus(itype(6'h23, 5'd0, 5'd0, 16'h0000), 32'h14C, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
        clockEdge();
        checkOutput("lw_r0_rt", EX_Rt, 0);
        applyStimulus(rtype(5'd0, 5'd0, 5'd6), 32'h150, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0);
        #1 checkOutput("r0_load_no_stall", Stall_Out, 0);
        clockEdge();
        checkOutput("r0_load_valid", EX_Valid, 1);
`ifdef ID_PERF_CNT_EN
        checkOutput("stall_count_two", Stall_Count, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
